sm4_round_engine: RTL
=====================

SM4_ROUND_ENGINE -- requirements
Module: sm4_round_engine

Interface
REQ-001 Parameter: mask_seed_p, 32'hACE1_2468, nonzero reset seed of the mask LFSR.
REQ-002 Parameter: masking_en_p, 1'b1, when 0 the data-round mask_i is tied to 0.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk_i  input  1  clock.
REQ-005 rst_ni  input  1  asynchronous active-low reset.
REQ-006 v_i  input  1  request valid.
REQ-007 ready_o  output  1  engine accepts a request.
REQ-008 is_key_i  input  1  1 = load key MK, 0 = process data block.
REQ-009 decrypt_i  input  1  data only; 1 = apply round keys in reverse order.
REQ-010 data_i  input  group_size_p (128)  key or data block, word 0 in the MSBs.
REQ-011 v_o  output  1  result valid.
REQ-012 ready_i  input  1  downstream accepts the result.
REQ-013 data_o  output  128  ciphertext or plaintext; 0 for key-load and error responses.
REQ-014 err_o  output  1  qualified by v_o; data request while no key is loaded.
REQ-015 key_ready_o  output  1  a complete 32-entry round-key set is stored.

Function
REQ-016 States: IDLE, KEY_RUN, DATA_RUN, DONE; transfers occur on v&ready.
REQ-017 ready_o is 1 only in IDLE, so a request cannot be accepted in the same cycle a result is consumed.
REQ-018 IDLE + accepted key: state <= data_i ^ FK, round counter <= 0, enter KEY_RUN.
REQ-019 IDLE + accepted data with key_ready_o = 1: state <= data_i, counter <= 0, enter DATA_RUN.
REQ-020 IDLE + accepted data with key_ready_o = 0: enter DONE with err_o = 1 and data_o = 0; no round is run.
REQ-021 Each run cycle performs one round with the turn_transform instance driven as follows:
- i = 128-bit state; o = new word.
- Shift: state <= {state[95:0], o}.
- Counter increments by 1.
REQ-022 KEY_RUN drives:
- is_key_i = 1; rkey_i = CK[counter].
- mask_i = 0; dismask_i = 0.
- Writes o to rk[counter].
REQ-023 DATA_RUN drives:
- is_key_i = 0; rkey_i = rk[counter] (encrypt) or rk[31-counter] (decrypt).
- mask_i = LFSR value; dismask_i = the instance's mask_o from the same cycle.
- The mask cancels combinationally, so o is unmasked.
REQ-024 The 32-bit Galois LFSR (taps 32,22,2,1) advances once per DATA_RUN cycle and holds otherwise.
REQ-025 Round 31 (counter = 31) is the exit condition:
- A run enters DONE after exactly 32 run cycles.
- KEY_RUN also sets key_ready_o.
REQ-026 Data result: data_o = word-reversed final state {X35,X34,X33,X32}.
REQ-027 Key result: data_o = 0 and err_o = 0.
REQ-028 Latency: accept at cycle T gives v_o = 1 at T+33; throughput is one block per 34 cycles with ready_i held high.
REQ-029 DONE holds v_o, data_o and err_o stable until ready_i, then returns to IDLE.
REQ-030 Loading a new key clears key_ready_o when accepted and sets it again at the end of KEY_RUN.

Reset
REQ-031 Reset values:
- State IDLE; ready_o = 1.
- v_o = 0, err_o = 0, data_o = 0.
- key_ready_o = 0; counter = 0; LFSR = mask_seed_p.
- rk contents are not reset.
REQ-032 Reset asserted mid-run aborts the run without emitting a result; key_ready_o = 0 afterwards.

Structure
REQ-033 FK[4], CK[32], the state enum and round_num_p = 32 belong in sm4_encryptor_pkg.
REQ-034 The block instantiates exactly one turn_transform as its sole sub-module.
REQ-035 rk is a 32x32 flop array.

Verification
REQ-036 Key 0123456789abcdeffedcba9876543210 -> v_o at T+33, err_o = 0, rk[0] = f12186f9, rk[31] = 9124a012, key_ready_o = 1.
REQ-037 Encrypt 0123456789abcdeffedcba9876543210 under that key -> 681edf34d206965e86b3e94f536e4246 at T+33, with both masking_en_p values.
REQ-038 Decrypt 681edf34d206965e86b3e94f536e4246 -> 0123456789abcdeffedcba9876543210.
REQ-039 Data request after reset with no key -> err_o = 1, data_o = 0 at T+1.
REQ-040 Hold ready_i = 0 for 10 cycles in DONE -> v_o/data_o stable and ready_o = 0; the release cycle returns to IDLE.
REQ-041 Drop rst_ni at round 15 of KEY_RUN -> no v_o, key_ready_o = 0, ready_o = 1 after reset release.

Source files
------------

// File: rtl/sm4_encryptor_pkg.sv
// sm4_encryptor_pkg
// Shared definitions for the SM4 round engine: engine FSM states, sizing
// constants, the SM4 system parameter FK, the fixed round constants CK,
// the SM4 S-box and small word helpers used by the engine and its round
// datapath.
package sm4_encryptor_pkg;

  localparam int unsigned group_size_p = 128;
  localparam int unsigned round_num_p  = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    KEY_RUN  = 2'd1,
    DATA_RUN = 2'd2,
    DONE     = 2'd3
  } state_e;

  localparam logic [31:0] FK [4] = '{
    32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc
  };

  localparam logic [31:0] CK [32] = '{
    32'h00070e15, 32'h1c232a31, 32'h383f464d, 32'h545b6269,
    32'h70777e85, 32'h8c939aa1, 32'ha8afb6bd, 32'hc4cbd2d9,
    32'he0e7eef5, 32'hfc030a11, 32'h181f262d, 32'h343b4249,
    32'h50575e65, 32'h6c737a81, 32'h888f969d, 32'ha4abb2b9,
    32'hc0c7ced5, 32'hdce3eaf1, 32'hf8ff060d, 32'h141b2229,
    32'h30373e45, 32'h4c535a61, 32'h686f767d, 32'h848b9299,
    32'ha0a7aeb5, 32'hbcc3cad1, 32'hd8dfe6ed, 32'hf4fb0209,
    32'h10171e25, 32'h2c333a41, 32'h484f565d, 32'h646b7279
  };

  localparam logic [7:0] SBOX [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  function automatic logic [31:0] rotl32(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Galois LFSR, x^32 + x^22 + x^2 + x + 1, right-shifting form.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0000_0000);
  endfunction

  // Reverse the order of the four 32-bit words of a block.
  function automatic logic [127:0] word_rev(input logic [127:0] b);
    return {b[31:0], b[63:32], b[95:64], b[127:96]};
  endfunction

endpackage

// File: rtl/sm4_round_engine_if.sv
// sm4_round_engine_if
// Request/response bundle of the SM4 round engine.
//   request : v_i, ready_o, is_key_i, decrypt_i, data_i
//   response: v_o, ready_i, data_o, err_o
//   status  : key_ready_o
// Modport slave is the engine side, master the requester side.
interface sm4_round_engine_if;
  import sm4_encryptor_pkg::*;

  logic                    v_i;
  logic                    ready_o;
  logic                    is_key_i;
  logic                    decrypt_i;
  logic [group_size_p-1:0] data_i;
  logic                    v_o;
  logic                    ready_i;
  logic [group_size_p-1:0] data_o;
  logic                    err_o;
  logic                    key_ready_o;

  modport slave (
    input  v_i, is_key_i, decrypt_i, data_i, ready_i,
    output ready_o, v_o, data_o, err_o, key_ready_o
  );

  modport master (
    output v_i, is_key_i, decrypt_i, data_i, ready_i,
    input  ready_o, v_o, data_o, err_o, key_ready_o
  );
endinterface

// File: rtl/turn_transform.sv
// turn_transform
// One SM4 round, purely combinational.
//   state_i   : current 128-bit state {X0,X1,X2,X3}
//   is_key_i  : 1 selects the key-schedule linear map L', 0 the cipher map L
//   rkey_i    : round key (data) or CK constant (key schedule)
//   mask_i    : additive mask applied to the X0 share
//   dismask_i : mask to strip from the result (normally mask_o)
//   mask_o    : the mask carried by the masked share
//   word_o    : new word X0 ^ T(X1^X2^X3^rkey)
module turn_transform
  import sm4_encryptor_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic         is_key_i,
  input  logic [31:0]  rkey_i,
  input  logic [31:0]  mask_i,
  input  logic [31:0]  dismask_i,
  output logic [31:0]  mask_o,
  output logic [31:0]  word_o
);

  logic [31:0] mix_in;
  logic [31:0] sub_out;
  logic [31:0] lin_out;
  logic [31:0] x0_masked;

  assign mix_in = state_i[95:64] ^ state_i[63:32] ^ state_i[31:0] ^ rkey_i;

  for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
    assign sub_out[gi*8 +: 8] = SBOX[mix_in[gi*8 +: 8]];
  end

  always_comb begin
    if (is_key_i) begin
      lin_out = sub_out ^ rotl32(sub_out, 13) ^ rotl32(sub_out, 23);
    end else begin
      lin_out = sub_out ^ rotl32(sub_out, 2) ^ rotl32(sub_out, 10)
              ^ rotl32(sub_out, 18) ^ rotl32(sub_out, 24);
    end
  end

  // X0 travels masked through the XOR tree; the mask leaves only at the
  // final XOR with dismask_i, so word_o is clear when dismask_i == mask_o.
  assign x0_masked = state_i[127:96] ^ mask_i;
  assign mask_o    = mask_i;
  assign word_o    = x0_masked ^ lin_out ^ dismask_i;

endmodule

// File: rtl/sm4_round_engine.sv
// sm4_round_engine
// Iterative SM4 engine: one round per clock. A key request expands MK into
// 32 round keys (stored in rk_q); a data request encrypts or decrypts one
// 128-bit block with the stored keys.
//   clk_i       : clock
//   rst_ni      : asynchronous active-low reset
//   bus (slave) : v_i/ready_o request handshake with is_key_i, decrypt_i,
//                 data_i; v_o/ready_i response handshake with data_o, err_o;
//                 key_ready_o status.
module sm4_round_engine
  import sm4_encryptor_pkg::*;
#(
  parameter logic [31:0] mask_seed_p  = 32'hACE1_2468,
  parameter bit          masking_en_p = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  sm4_round_engine_if.slave bus
);

  localparam logic [127:0] fk_word = {FK[0], FK[1], FK[2], FK[3]};
  localparam logic [4:0]   last_cnt = 5'(round_num_p - 1);

  state_e       st_q, st_d;
  logic [127:0] blk_q, blk_d;
  logic [4:0]   cnt_q, cnt_d;
  logic [31:0]  lfsr_q, lfsr_d;
  logic         key_ready_q, key_ready_d;
  logic         is_key_q, is_key_d;
  logic         dec_q, dec_d;
  logic         err_q, err_d;
  logic [31:0]  rk_q [round_num_p];

  logic         accept;
  logic         last_round;
  logic         key_run;
  logic         data_run;
  logic [31:0]  rkey_sel;
  logic [31:0]  mask_in;
  logic [31:0]  mask_out;
  logic [31:0]  dismask_in;
  logic [31:0]  rnd_word;

  assign accept     = bus.v_i && (st_q == IDLE);
  assign last_round = (cnt_q == last_cnt);
  assign key_run    = (st_q == KEY_RUN);
  assign data_run   = (st_q == DATA_RUN);

  // Decryption walks the schedule backwards: rk[31-cnt] == rk[~cnt].
  assign rkey_sel   = key_run ? CK[cnt_q] : rk_q[dec_q ? ~cnt_q : cnt_q];
  assign mask_in    = (data_run && masking_en_p) ? lfsr_q : 32'h0;
  assign dismask_in = data_run ? mask_out : 32'h0;

  turn_transform u_turn (
    .state_i   (blk_q),
    .is_key_i  (key_run),
    .rkey_i    (rkey_sel),
    .mask_i    (mask_in),
    .dismask_i (dismask_in),
    .mask_o    (mask_out),
    .word_o    (rnd_word)
  );

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q <= IDLE;
    end else begin
      st_q <= st_d;
    end
  end

  // FSM next state
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE: begin
        if (accept) begin
          if (bus.is_key_i)  st_d = KEY_RUN;
          else if (key_ready_q) st_d = DATA_RUN;
          else               st_d = DONE;
        end
      end
      KEY_RUN, DATA_RUN: if (last_round) st_d = DONE;
      DONE:              if (bus.ready_i) st_d = IDLE;
      default:           st_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.ready_o     = (st_q == IDLE);
    bus.v_o         = (st_q == DONE);
    bus.err_o       = (st_q == DONE) && err_q;
    bus.key_ready_o = key_ready_q;
    // Final state is {X32,X33,X34,X35}; the result is its word reversal.
    bus.data_o      = ((st_q == DONE) && !is_key_q && !err_q) ? word_rev(blk_q) : '0;
  end

  // Datapath next state
  always_comb begin
    blk_d       = blk_q;
    cnt_d       = cnt_q;
    lfsr_d      = lfsr_q;
    key_ready_d = key_ready_q;
    is_key_d    = is_key_q;
    dec_d       = dec_q;
    err_d       = err_q;
    unique case (st_q)
      IDLE: begin
        if (accept) begin
          is_key_d = bus.is_key_i;
          dec_d    = bus.decrypt_i;
          err_d    = !bus.is_key_i && !key_ready_q;
          cnt_d    = '0;
          blk_d    = bus.is_key_i ? (bus.data_i ^ fk_word) : bus.data_i;
          if (bus.is_key_i) key_ready_d = 1'b0;
        end
      end
      KEY_RUN, DATA_RUN: begin
        blk_d = {blk_q[95:0], rnd_word};
        cnt_d = cnt_q + 5'd1;
        if (data_run) lfsr_d = lfsr_next(lfsr_q);
        if (key_run && last_round) key_ready_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      blk_q       <= '0;
      cnt_q       <= '0;
      lfsr_q      <= mask_seed_p;
      key_ready_q <= 1'b0;
      is_key_q    <= 1'b0;
      dec_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      blk_q       <= blk_d;
      cnt_q       <= cnt_d;
      lfsr_q      <= lfsr_d;
      key_ready_q <= key_ready_d;
      is_key_q    <= is_key_d;
      dec_q       <= dec_d;
      err_q       <= err_d;
    end
  end

  // Round-key store; contents are don't-care until key_ready_o is set.
  always_ff @(posedge clk_i) begin
    if (key_run) begin
      rk_q[cnt_q] <= rnd_word;
    end
  end

endmodule
